// File: rtl/lz4_byte_packer.sv
// Purpose : LZ4 input stage. Packs a byte stream into 32-bit words, buffers them in a FIFO and flags the block tail.
// Latency : a word is stored one cycle after its last byte is accepted; popped data appears one cycle after rd_fifo_en.
// Backpr. : in_ready drops while the FIFO is full, and while an ended block waits for its final word to be popped.
//
// Ports   : clk/rstN (async active-low); in_byte/in_valid/in_last/in_ready byte input;
//           rd_fifo_en -> fifo_data/fifo_valid registered pop port, fifo_empty;
//           last_5bytes/tail_bytes/block_done block-tail flags; byte_count accepted-byte counter.
// Config  : define LZ4_PACKER_BYTECNT_EN to build the byte counter; otherwise byte_count is tied to 0.
module lz4_byte_packer #(
    parameter int DEPTH       = 16,
    parameter int LAST_THRESH = 5
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        rd_fifo_en,
    output logic [31:0] fifo_data,
    output logic        fifo_valid,
    output logic        fifo_empty,
    output logic        last_5bytes,
    output logic [1:0]  tail_bytes,
    output logic        block_done,
    output logic [31:0] byte_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int VW = AW + 3;

    typedef enum logic {PACK, DRAIN} state_t;

    state_t        state_q, state_d;
    logic          ready_en_q;   // keeps in_ready low during the first cycle after reset
    logic [31:0]   pack_reg;
    logic [1:0]    pack_cnt;
    logic [31:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, fill;
    logic          fifo_full;
    logic          accept, push, pop, last_pop;
    logic [31:0]   push_word;
    logic [2:0]    push_bytes, tail_val, push_add, pop_sub;
    logic [VW-1:0] vbytes;
    logic [1:0]    tail_q;

    assign fill       = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    // fill never exceeds DEPTH, so its MSB alone marks a full FIFO
    assign fifo_full  = fill[AW];

    assign accept   = in_valid && in_ready;
    assign push     = accept && ((pack_cnt == 2'd3) || in_last);
    assign pop      = rd_fifo_en && !fifo_empty;
    // While draining the FIFO holds only the ended block, so its last word is the final one
    assign last_pop = pop && (state_q == DRAIN) && (fill == (AW+1)'(1));

    assign push_bytes = {1'b0, pack_cnt} + 3'd1;
    assign tail_val   = (tail_q == 2'd0) ? 3'd4 : {1'b0, tail_q};
    assign push_add   = push ? push_bytes : 3'd0;
    assign pop_sub    = pop ? (last_pop ? tail_val : 3'd4) : 3'd0;

    assign last_5bytes = (state_q == DRAIN) && (vbytes <= VW'(LAST_THRESH));
    assign tail_bytes  = tail_q;

    // Merge the incoming byte into its lane; lane 3 holds the first byte of the word
    always_comb begin
        push_word = pack_reg;
        case (pack_cnt)
            2'd0: push_word[31:24] = in_byte;
            2'd1: push_word[23:16] = in_byte;
            2'd2: push_word[15:8]  = in_byte;
            2'd3: push_word[7:0]   = in_byte;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            PACK: begin
                in_ready = ready_en_q && !fifo_full;
                if (in_valid && ready_en_q && !fifo_full && in_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (last_pop) state_d = PACK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= PACK;
            ready_en_q <= 1'b0;
            pack_reg   <= 32'd0;
            pack_cnt   <= 2'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            vbytes     <= '0;
            tail_q     <= 2'd0;
            fifo_data  <= 32'd0;
            fifo_valid <= 1'b0;
            block_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            fifo_valid <= pop;
            block_done <= last_pop;
            vbytes     <= vbytes + {{(VW-3){1'b0}}, push_add} - {{(VW-3){1'b0}}, pop_sub};
            if (pop) begin
                fifo_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr    <= rd_ptr + (AW+1)'(1);
            end
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (accept) begin
                // Any non-final byte belongs to a new or ongoing block, so the old tail is dropped
                tail_q <= in_last ? push_bytes[1:0] : 2'd0;
                if (push) begin
                    pack_reg <= 32'd0;
                    pack_cnt <= 2'd0;
                end else begin
                    pack_reg <= push_word;
                    pack_cnt <= pack_cnt + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_word;
    end

`ifdef LZ4_PACKER_BYTECNT_EN
    logic [31:0] byte_cnt_q;
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)       byte_cnt_q <= 32'd0;
        else if (accept) byte_cnt_q <= byte_cnt_q + 32'd1;
    end
    assign byte_count = byte_cnt_q;
`else
    assign byte_count = 32'd0;
`endif

endmodule

// File: tb/tb_lz4_byte_packer.sv
module tb_lz4_byte_packer;
    localparam int DEPTH  = 16;
    localparam int THRESH = 5;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic [7:0]  in_byte = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        rd_fifo_en = 1'b0;
    logic [31:0] fifo_data;
    logic        fifo_valid;
    logic        fifo_empty;
    logic        last_5bytes;
    logic [1:0]  tail_bytes;
    logic        block_done;
    logic [31:0] byte_count;

    int checks = 0;
    int failures = 0;

    lz4_byte_packer #(.DEPTH(DEPTH), .LAST_THRESH(THRESH)) dut (
        .clk(clk), .rstN(rstN), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .rd_fifo_en(rd_fifo_en), .fifo_data(fifo_data),
        .fifo_valid(fifo_valid), .fifo_empty(fifo_empty), .last_5bytes(last_5bytes),
        .tail_bytes(tail_bytes), .block_done(block_done), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    // Reference model: stored words with their valid-byte counts, bytes of the word being built
    logic [31:0] q_word[$];
    int          q_nb[$];
    logic [7:0]  cur[$];
    bit          up, drain, tail_known;
    int          tail;
    bit          e_fv, e_bd;
    logic [31:0] e_fd;
    logic [31:0] acc;

    function automatic int stored_bytes();
        int s = 0;
        foreach (q_nb[i]) s += q_nb[i];
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_word.delete(); q_nb.delete(); cur.delete();
        up = 0; drain = 0; tail_known = 1; tail = 0;
        e_fv = 0; e_bd = 0; e_fd = 32'd0; acc = 32'd0;
    endtask

    task automatic compare_all();
        chk("in_ready", in_ready, up && !drain && (q_word.size() < DEPTH));
        chk("fifo_empty", fifo_empty, q_word.size() == 0);
        chk("fifo_valid", fifo_valid, e_fv);
        chk("fifo_data", fifo_data, e_fd);
        chk("block_done", block_done, e_bd);
        chk("last_5bytes", last_5bytes, drain && (stored_bytes() <= THRESH));
        if (tail_known) chk("tail_bytes", tail_bytes, tail);
`ifdef LZ4_PACKER_BYTECNT_EN
        chk("byte_count", byte_count, acc);
`else
        chk("byte_count", byte_count, 32'd0);
`endif
    endtask

    task automatic model_advance(input logic v, input logic [7:0] b, input logic l, input logic r);
        bit rdy, popped, lastpop;
        logic [31:0] w;
        int dummy;
        rdy     = up && !drain && (q_word.size() < DEPTH);
        popped  = r && (q_word.size() > 0);
        lastpop = popped && drain && (q_word.size() == 1);
        e_fv = popped;
        e_bd = lastpop;
        if (popped) begin
            e_fd  = q_word.pop_front();
            dummy = q_nb.pop_front();
        end
        if (lastpop) drain = 0;
        if (v && rdy) begin
            acc = acc + 32'd1;
            cur.push_back(b);
            tail_known = 0;
            if (cur.size() == 4 || l) begin
                w = 32'd0;
                for (int i = 0; i < cur.size(); i++) w[31-8*i -: 8] = cur[i];
                q_word.push_back(w);
                q_nb.push_back(cur.size());
                if (l) begin
                    drain = 1;
                    tail = cur.size() % 4;
                    tail_known = 1;
                end
                cur.delete();
            end
        end
        up = 1;
    endtask

    // Compare current outputs, apply one cycle of inputs, advance to just after the next edge
    task automatic cycle(input logic v, input logic [7:0] b, input logic l, input logic r);
        compare_all();
        in_valid = v; in_byte = b; in_last = l; rd_fifo_en = r;
        model_advance(v, b, l, r);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic l);
        cycle(1'b1, b, l, 1'b0);
    endtask

    task automatic do_reset();
        in_valid = 0; in_last = 0; rd_fifo_en = 0;
        rstN = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_fifo_data", fifo_data, 32'd0);
        chk("rst_fifo_valid", fifo_valid, 1'b0);
        chk("rst_fifo_empty", fifo_empty, 1'b1);
        chk("rst_last_5bytes", last_5bytes, 1'b0);
        chk("rst_tail_bytes", tail_bytes, 2'd0);
        chk("rst_block_done", block_done, 1'b0);
        chk("rst_byte_count", byte_count, 32'd0);
        model_reset();
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        do_reset();
        cycle(0, 8'h00, 0, 0);
        chk("ready_after_reset", in_ready, 1'b1);

        // Single word, then pop
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h44, 0);
        chk("stored_not_empty", fifo_empty, 1'b0);
        cycle(0, 8'h00, 0, 1);
        chk("pop1_valid", fifo_valid, 1'b1);
        chk("pop1_data", fifo_data, 32'h11223344);

        // Six-byte block ending in a partial word
        for (int i = 1; i <= 6; i++) push(8'(i), i == 6);
        chk("blk_tail", tail_bytes, 2'd2);
        chk("blk_l5_before", last_5bytes, 1'b0);
        chk("blk_ready_drain", in_ready, 1'b0);
        cycle(0, 8'h00, 0, 1);
        chk("blk_w0", fifo_data, 32'h01020304);
        chk("blk_l5_after", last_5bytes, 1'b1);
        cycle(0, 8'h00, 0, 1);
        chk("blk_w1", fifo_data, 32'h05060000);
        chk("blk_done", block_done, 1'b1);
        chk("blk_done_valid", fifo_valid, 1'b1);
        cycle(0, 8'h00, 0, 0);
        chk("blk_done_pulse", block_done, 1'b0);
        chk("blk_ready_back", in_ready, 1'b1);

        // Pop requests while empty, then push+pop at count 1
        repeat (3) cycle(0, 8'h00, 0, 1);
        chk("empty_pop_valid", fifo_valid, 1'b0);
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), 0);
        for (int i = 0; i < 3; i++) push(8'hB0 + 8'(i), 0);
        cycle(1, 8'hB3, 0, 1);
        chk("pushpop_not_empty", fifo_empty, 1'b0);
        chk("pushpop_data", fifo_data, 32'hA0A1A2A3);
        cycle(0, 8'h00, 0, 1);
        chk("pushpop_data2", fifo_data, 32'hB0B1B2B3);
        chk("pushpop_empty", fifo_empty, 1'b1);

        // Fill to DEPTH words, across pointer wrap
        for (int i = 0; i < 4 * DEPTH; i++) push(8'($urandom), 0);
        chk("full_ready", in_ready, 1'b0);
        chk("full_not_empty", fifo_empty, 1'b0);
        cycle(1, 8'h5A, 0, 0);
        cycle(0, 8'h00, 0, 1);
        chk("full_ready_after_pop", in_ready, 1'b1);
        repeat (DEPTH) cycle(0, 8'h00, 0, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1);
        repeat (2 * DEPTH + 2) cycle(0, 8'h00, 0, 1);

        // Reset mid-word discards partial bytes
        push(8'h01, 0); push(8'h02, 0); push(8'h03, 0);
        do_reset();
        cycle(0, 8'h00, 0, 0);
        push(8'hAA, 0); push(8'hBB, 0); push(8'hCC, 0); push(8'hDD, 0);
        cycle(0, 8'h00, 0, 1);
        chk("post_reset_word", fifo_data, 32'hAABBCCDD);

        // Byte counter
        do_reset();
        cycle(0, 8'h00, 0, 0);
        for (int i = 0; i < 9; i++) push(8'h30 + 8'(i), 0);
`ifdef LZ4_PACKER_BYTECNT_EN
        chk("byte_count_9", byte_count, 32'd9);
`else
        chk("byte_count_off", byte_count, 32'd0);
`endif
        compare_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lz4_byte_packer.md
# lz4_byte_packer

Input stage of the LZ4 compressor. Accepts the raw byte stream one byte per cycle, packs bytes into 32-bit words and buffers them in an internal synchronous FIFO. It serves them to the byte-addressing/shifter stage through a registered-read FIFO port (rd_fifo_en → fifo_valid one cycle later). It also flags the tail of each block (last_5bytes, tail_bytes), so the match engine stops issuing matches at the end of the input.

## Interface
- DEPTH, 16: FIFO depth in 32-bit words; power of two, ≥4.
- LAST_THRESH, 5: last_5bytes asserts when unpopped valid bytes of an ended block ≤ this value.
- clk  in  1  single clock, rising edge.
- rstN  in  1  asynchronous, active-low reset.
- in_byte  in  8  input byte.
- in_valid  in  1  in_byte valid.
- in_last  in  1  qualifies the final byte of a block; sampled with in_valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- rd_fifo_en  in  1  pop request from downstream.
- fifo_data  out  32  popped word; first stream byte in [31:24].
- fifo_valid  out  1  fifo_data valid, one cycle after an effective pop.
- fifo_empty  out  1  no word stored.
- last_5bytes  out  1  block ended and unpopped valid bytes ≤ LAST_THRESH.
- tail_bytes  out  2  valid bytes in the block's final word (0 means 4).
- block_done  out  1  one-cycle pulse when the block's final word is popped.
- byte_count  out  32  accepted bytes since reset (see Configuration).

## Operation
- Packing: pack_reg[31:0] and pack_cnt[1:0].
  - An accepted byte goes to lane 3-pack_cnt (lane 3 = [31:24]).
  - On the 4th byte, or on in_last, the word is written to the FIFO and pack_cnt clears.
  - Unused lanes of a partial word are 0.
- FSM states:
  - PACK: accepting bytes. in_ready = !fifo_full.
    - Accepted byte with in_last and pack_cnt==3 → DRAIN (the write happens the same cycle).
    - Accepted byte with in_last and pack_cnt<3 → DRAIN (partial word written the same cycle, tail_bytes = pack_cnt+1 mod 4).
  - DRAIN: in_ready = 0. Waits until the final word is popped. On that pop, block_done pulses next cycle with fifo_valid → PACK.
- FIFO: DEPTH words, wr/rd pointers of log2(DEPTH)+1 bits; full/empty are derived from the pointers.
  - Effective pop = rd_fifo_en && !fifo_empty.
  - A pop request while empty is ignored; fifo_valid stays 0.
  - A write while full cannot occur, because in_ready is gated.
  - Simultaneous push and pop are both performed and the count is unchanged.
- fifo_data is registered. It updates only on an effective pop and holds its value otherwise.
- Valid-byte counter vbytes (log2(DEPTH)+3 bits):
  - +4 per full-word push, +tail_bytes per partial push, −valid bytes of the popped word.
  - last_5bytes = in DRAIN && vbytes ≤ LAST_THRESH, combinational from registers.
- tail_bytes holds its value from the final push until the next block's first byte is accepted.

## Timing
- Reset values: in_ready 0, fifo_data 0, fifo_valid 0, fifo_empty 1, last_5bytes 0, tail_bytes 0, block_done 0, byte_count 0. FSM enters PACK.
- in_ready rises the first cycle after reset is released.
- Latency: the 4th byte is accepted at cycle N; the word is stored at N+1, and fifo_empty falls at N+1.
- An effective pop at cycle M gives fifo_valid = 1 and fifo_data = word at M+1.
- Wrap-around: the pointer MSB distinguishes full from empty; no bubble at wrap.
- Reset asserted mid-block: all state clears asynchronously and partial bytes are discarded.

## Configuration
- LZ4_PACKER_BYTECNT_EN defined: byte_count increments per accepted byte and wraps modulo 2^32.
- LZ4_PACKER_BYTECNT_EN undefined: byte_count is tied to 0 and the counter is not synthesised.

## Test plan
- Push bytes 0x11,0x22,0x33,0x44; pop → fifo_data = 0x11223344, fifo_valid 1 cycle after rd_fifo_en.
- Push 6 bytes 0x01..0x06 with in_last on 0x06 → two words 0x01020304 and 0x05060000, tail_bytes = 2. last_5bytes is 1 after the first pop (vbytes = 2). block_done pulses with the second fifo_valid.
- Fill DEPTH words without popping → in_ready = 0 and fifo_empty = 0. One pop → in_ready = 1 next cycle. Data order is preserved across pointer wrap.
- rd_fifo_en held high while empty → fifo_valid stays 0, pointers unchanged. Simultaneous push and pop at count 1 → count stays 1.
- Assert rstN low after 3 bytes of a word → all outputs take their reset values. The next 4 bytes form a clean word.
- With LZ4_PACKER_BYTECNT_EN defined, push 9 bytes → byte_count = 9. Without it → byte_count = 0.
